// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB core definitions: op codes, sequencer states and default TLB depth.
package tlb_op_ctrl_pkg;

   localparam int TLBNUM_DEF = 32;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DONE  = 2'd3
   } tlb_state_e;

endpackage

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance-op sequencer: drains in-flight translations, issues one
// TLB access strobe, then reports completion (and TLBIDX write-back for SRCH).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready for a new op, translations allowed
// ST_DRAIN | op captured, stalling translations until trans_idle
// ST_EXEC  | single cycle issuing the op's TLB strobe
// ST_DONE  | done pulse, TLBIDX write-back for SRCH
module tlb_op_ctrl
   import tlb_op_ctrl_pkg::*;
#(
   parameter int TLBNUM = TLBNUM_DEF,
   localparam int IW = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [2:0]    op_code,
   input  logic [4:0]    inv_op,
   input  logic [9:0]    inv_asid,
   input  logic [18:0]   inv_vpn,
   input  logic [31:0]   csr_tlbehi,
   input  logic [IW-1:0] csr_tlbidx_index,
   input  logic          trans_idle,
   output logic          trans_stall,
   output logic          srch_valid,
   output logic [18:0]   srch_vppn,
   input  logic          srch_found,
   input  logic [IW-1:0] srch_index,
   output logic          tlb_wen,
   output logic [IW-1:0] tlb_windex,
   output logic          tlbinv_en,
   output logic [4:0]    tlbinv_op,
   output logic [9:0]    tlbinv_asid,
   output logic [18:0]   tlbinv_vpn,
   output logic          rd_we,
   output logic          csr_idx_we,
   output logic          csr_idx_ne,
   output logic [IW-1:0] csr_idx_index,
   output logic          done
);

   tlb_state_e    r_state;
   tlb_state_e    w_next;
   logic [IW-1:0] r_fill_cnt;
   logic [2:0]    r_op;
   logic [4:0]    r_inv_op;
   logic [9:0]    r_inv_asid;
   logic [18:0]   r_inv_vpn;
   logic          r_found;
   logic [IW-1:0] r_found_idx;
   logic          w_accept;
   logic          w_unused_ok;

   // low TLBEHI bits carry no VPPN information
   assign w_unused_ok = &{1'b0, csr_tlbehi[12:0]};

   // op_ready is held low while reset is asserted even though state is IDLE
   assign w_accept = op_valid && op_ready;

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // free-running fill index, wraps at TLBNUM-1 for non-power-of-two depths
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                              r_fill_cnt <= '0;
      else if (r_fill_cnt == IW'(TLBNUM - 1))   r_fill_cnt <= '0;
      else                                      r_fill_cnt <= r_fill_cnt + IW'(1);
   end

   // capture op fields at accept and search result during EXEC
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_op        <= '0;
         r_inv_op    <= '0;
         r_inv_asid  <= '0;
         r_inv_vpn   <= '0;
         r_found     <= 1'b0;
         r_found_idx <= '0;
      end else begin
         if (w_accept) begin
            r_op       <= op_code;
            r_inv_op   <= inv_op;
            r_inv_asid <= inv_asid;
            r_inv_vpn  <= inv_vpn;
         end
         if (r_state == ST_EXEC && r_op == OP_SRCH) begin
            r_found     <= srch_found;
            r_found_idx <= srch_index;
         end
      end
   end

   // next-state and Moore outputs; data outputs stay 0 unless their strobe is set
   always_comb begin
      w_next        = r_state;
      op_ready      = 1'b0;
      trans_stall   = 1'b0;
      srch_valid    = 1'b0;
      srch_vppn     = '0;
      tlb_wen       = 1'b0;
      tlb_windex    = '0;
      tlbinv_en     = 1'b0;
      tlbinv_op     = '0;
      tlbinv_asid   = '0;
      tlbinv_vpn    = '0;
      rd_we         = 1'b0;
      csr_idx_we    = 1'b0;
      csr_idx_ne    = 1'b0;
      csr_idx_index = '0;
      done          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            op_ready = resetn;
            if (op_valid && resetn) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            trans_stall = 1'b1;
            if (trans_idle) w_next = ST_EXEC;
         end
         ST_EXEC: begin
            trans_stall = 1'b1;
            w_next      = ST_DONE;
            case (r_op)
               OP_SRCH: begin
                  srch_valid = 1'b1;
                  srch_vppn  = csr_tlbehi[31:13];
               end
               OP_RD: rd_we = 1'b1;
               OP_WR: begin
                  tlb_wen    = 1'b1;
                  tlb_windex = csr_tlbidx_index;
               end
               OP_FILL: begin
                  tlb_wen    = 1'b1;
                  tlb_windex = r_fill_cnt;
               end
               OP_INV: begin
                  tlbinv_en   = 1'b1;
                  tlbinv_op   = r_inv_op;
                  tlbinv_asid = r_inv_asid;
                  tlbinv_vpn  = r_inv_vpn;
               end
               default: ;
            endcase
         end
         ST_DONE: begin
            trans_stall = 1'b1;
            done        = 1'b1;
            w_next      = ST_IDLE;
            if (r_op == OP_SRCH) begin
               csr_idx_we    = 1'b1;
               csr_idx_ne    = !r_found;
               csr_idx_index = r_found ? r_found_idx : '0;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_tlb_op_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code;
   logic [4:0]  inv_op;
   logic [9:0]  inv_asid;
   logic [18:0] inv_vpn;
   logic [31:0] csr_tlbehi;
   logic [4:0]  csr_tlbidx_index;
   logic        trans_idle;
   logic        trans_stall;
   logic        srch_valid;
   logic [18:0] srch_vppn;
   logic        srch_found;
   logic [4:0]  srch_index;
   logic        tlb_wen;
   logic [4:0]  tlb_windex;
   logic        tlbinv_en;
   logic [4:0]  tlbinv_op;
   logic [9:0]  tlbinv_asid;
   logic [18:0] tlbinv_vpn;
   logic        rd_we;
   logic        csr_idx_we;
   logic        csr_idx_ne;
   logic [4:0]  csr_idx_index;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tlb_op_ctrl dut (
      .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
      .csr_tlbehi(csr_tlbehi), .csr_tlbidx_index(csr_tlbidx_index),
      .trans_idle(trans_idle), .trans_stall(trans_stall),
      .srch_valid(srch_valid), .srch_vppn(srch_vppn),
      .srch_found(srch_found), .srch_index(srch_index),
      .tlb_wen(tlb_wen), .tlb_windex(tlb_windex),
      .tlbinv_en(tlbinv_en), .tlbinv_op(tlbinv_op),
      .tlbinv_asid(tlbinv_asid), .tlbinv_vpn(tlbinv_vpn),
      .rd_we(rd_we), .csr_idx_we(csr_idx_we), .csr_idx_ne(csr_idx_ne),
      .csr_idx_index(csr_idx_index), .done(done)
   );

   wire [5:0] strobes = {srch_valid, tlb_wen, tlbinv_en, rd_we, csr_idx_we, done};
   wire       any_out = |{op_ready, trans_stall, strobes, srch_vppn, tlb_windex,
                          tlbinv_op, tlbinv_asid, tlbinv_vpn, csr_idx_ne, csr_idx_index};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // present an op at the current falling edge; returns at the falling edge of the first DRAIN cycle
   task automatic offer(input logic [2:0] code, input logic [4:0] iop,
                        input logic [9:0] iasid, input logic [18:0] ivpn);
      op_valid = 1'b1;
      op_code  = code;
      inv_op   = iop;
      inv_asid = iasid;
      inv_vpn  = ivpn;
      chk("offer_ready", {31'd0, op_ready}, 32'd1);
      @(negedge clk);
      op_valid = 1'b0;
      chk("drain_stall", {31'd0, trans_stall}, 32'd1);
      chk("drain_not_ready", {31'd0, op_ready}, 32'd0);
   endtask

   initial begin
      resetn = 1'b0; op_valid = 1'b0; op_code = '0; inv_op = '0; inv_asid = '0;
      inv_vpn = '0; csr_tlbehi = '0; csr_tlbidx_index = 5'd7; trans_idle = 1'b1;
      srch_found = 1'b0; srch_index = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, op_ready}, 32'd0);
      chk("rst_all_out", {31'd0, any_out}, 32'd0);
      resetn = 1'b1;
      #1 chk("rel_ready", {31'd0, op_ready}, 32'd1);
      chk("rel_stall", {31'd0, trans_stall}, 32'd0);

      // FILL accepted in cycle 10 after release -> EXEC in cycle 12
      repeat (10) @(posedge clk);
      @(negedge clk);
      offer(3'd3, 5'd0, 10'd0, 19'd0);
      chk("fill1_drain_wen", {31'd0, tlb_wen}, 32'd0);
      @(negedge clk);
      chk("fill1_wen", {31'd0, tlb_wen}, 32'd1);
      chk("fill1_windex", {27'd0, tlb_windex}, 32'd12);
      @(negedge clk);
      chk("fill1_done", {31'd0, done}, 32'd1);
      chk("fill1_wen_off", {31'd0, tlb_wen}, 32'd0);
      @(negedge clk);
      chk("fill1_idle_ready", {31'd0, op_ready}, 32'd1);
      // second FILL accepted 28 cycles later (cycle 38) -> EXEC cycle 40 -> index 8
      repeat (24) @(negedge clk);
      offer(3'd3, 5'd0, 10'd0, 19'd0);
      @(negedge clk);
      chk("fill2_wen", {31'd0, tlb_wen}, 32'd1);
      chk("fill2_windex", {27'd0, tlb_windex}, 32'd8);
      @(negedge clk);
      @(negedge clk);

      // WR: tlb_wen 2 cycles after accept, done 3 cycles after
      csr_tlbidx_index = 5'd7;
      offer(3'd2, 5'd0, 10'd0, 19'd0);
      chk("wr_drain_strobes", {26'd0, strobes}, 32'd0);
      @(negedge clk);
      chk("wr_wen", {31'd0, tlb_wen}, 32'd1);
      chk("wr_windex", {27'd0, tlb_windex}, 32'd7);
      chk("wr_exec_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("wr_done", {31'd0, done}, 32'd1);
      chk("wr_wen_off", {31'd0, tlb_wen}, 32'd0);
      chk("wr_windex_off", {27'd0, tlb_windex}, 32'd0);
      @(negedge clk);
      chk("wr_idle_done", {31'd0, done}, 32'd0);
      chk("wr_idle_stall", {31'd0, trans_stall}, 32'd0);

      // SRCH hit then miss
      csr_tlbehi = 32'h0040_2000; srch_found = 1'b1; srch_index = 5'd9;
      offer(3'd0, 5'd0, 10'd0, 19'd0);
      chk("srch_drain_valid", {31'd0, srch_valid}, 32'd0);
      @(negedge clk);
      chk("srch_valid", {31'd0, srch_valid}, 32'd1);
      chk("srch_vppn", {13'd0, srch_vppn}, 32'h201);
      @(negedge clk);
      chk("srch_idx_we", {31'd0, csr_idx_we}, 32'd1);
      chk("srch_idx_ne", {31'd0, csr_idx_ne}, 32'd0);
      chk("srch_idx_index", {27'd0, csr_idx_index}, 32'd9);
      chk("srch_done", {31'd0, done}, 32'd1);
      chk("srch_valid_off", {31'd0, srch_valid}, 32'd0);
      @(negedge clk);
      chk("srch_idx_we_off", {31'd0, csr_idx_we}, 32'd0);
      srch_found = 1'b0;
      offer(3'd0, 5'd0, 10'd0, 19'd0);
      @(negedge clk);
      chk("miss_valid", {31'd0, srch_valid}, 32'd1);
      @(negedge clk);
      chk("miss_idx_we", {31'd0, csr_idx_we}, 32'd1);
      chk("miss_idx_ne", {31'd0, csr_idx_ne}, 32'd1);
      chk("miss_idx_index", {27'd0, csr_idx_index}, 32'd0);
      @(negedge clk);

      // INV with translations busy for 4 cycles; inputs change after accept
      trans_idle = 1'b0;
      offer(3'd4, 5'h03, 10'h2A5, 19'h5A5A5);
      inv_op = 5'h1F; inv_asid = 10'h3FF; inv_vpn = 19'h7FFFF;
      for (int i = 0; i < 4; i++) begin
         chk("inv_drain_stall", {31'd0, trans_stall}, 32'd1);
         chk("inv_drain_en", {31'd0, tlbinv_en}, 32'd0);
         if (i == 3) trans_idle = 1'b1;
         @(negedge clk);
      end
      chk("inv_en", {31'd0, tlbinv_en}, 32'd1);
      chk("inv_op", {27'd0, tlbinv_op}, 32'h03);
      chk("inv_asid", {22'd0, tlbinv_asid}, 32'h2A5);
      chk("inv_vpn", {13'd0, tlbinv_vpn}, 32'h5A5A5);
      chk("inv_exec_stall", {31'd0, trans_stall}, 32'd1);
      @(negedge clk);
      chk("inv_en_off", {31'd0, tlbinv_en}, 32'd0);
      chk("inv_op_off", {27'd0, tlbinv_op}, 32'd0);
      chk("inv_done", {31'd0, done}, 32'd1);
      chk("inv_done_stall", {31'd0, trans_stall}, 32'd1);
      @(negedge clk);

      // RD with op_valid held high, then reserved op 6 accepted only in IDLE
      offer(3'd1, 5'd0, 10'd0, 19'd0);
      op_valid = 1'b1; op_code = 3'd6;
      @(negedge clk);
      chk("rd_we", {31'd0, rd_we}, 32'd1);
      chk("rd_busy_ready", {31'd0, op_ready}, 32'd0);
      @(negedge clk);
      chk("rd_we_off", {31'd0, rd_we}, 32'd0);
      chk("rd_done", {31'd0, done}, 32'd1);
      chk("rd_done_ready", {31'd0, op_ready}, 32'd0);
      @(negedge clk);
      chk("rsv_idle_ready", {31'd0, op_ready}, 32'd1);
      @(negedge clk);
      op_valid = 1'b0;
      chk("rsv_drain_stall", {31'd0, trans_stall}, 32'd1);
      @(negedge clk);
      chk("rsv_exec_strobes", {26'd0, strobes}, 32'd0);
      @(negedge clk);
      chk("rsv_done_strobes", {26'd0, strobes}, 32'h01);
      @(negedge clk);
      chk("rsv_idle_strobes", {26'd0, strobes}, 32'd0);

      // reset asserted during DRAIN of a WR
      trans_idle = 1'b0;
      offer(3'd2, 5'd0, 10'd0, 19'd0);
      trans_idle = 1'b1;
      resetn = 1'b0;
      #1 chk("mid_rst_out", {31'd0, any_out}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("mid_rst_edge_out", {31'd0, any_out}, 32'd0);
      end
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_strobes", {26'd0, strobes}, 32'd0);
      end
      chk("post_rst_ready", {31'd0, op_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 32, giving the number of TLB entries; index width is clog2(TLBNUM).
REQ-002 SHALL have these ports, in this order:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- op_valid  in  1  a TLB-maintenance op is offered.
- op_ready  out  1  the block can accept an op.
- op_code  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV, 5-7 reserved.
- inv_op  in  5  INVTLB op field.
- inv_asid  in  10  INVTLB ASID.
- inv_vpn  in  19  INVTLB VPPN.
- csr_tlbehi  in  32  current TLBEHI; VPPN is bits [31:13].
- csr_tlbidx_index  in  clog2(TLBNUM)  current TLBIDX.INDEX.
- trans_idle  in  1  no inst or data translation is in flight.
- trans_stall  out  1  blocks new inst/data translation requests.
- srch_valid  out  1  TLB search strobe.
- srch_vppn  out  19  search VPPN.
- srch_found  in  1  search hit, valid in the same cycle as srch_valid.
- srch_index  in  clog2(TLBNUM)  index of the hit entry.
- tlb_wen  out  1  TLB write strobe.
- tlb_windex  out  clog2(TLBNUM)  write index.
- tlbinv_en  out  1  invalidate strobe.
- tlbinv_op  out  5  invalidate op.
- tlbinv_asid  out  10  invalidate ASID.
- tlbinv_vpn  out  19  invalidate VPPN.
- rd_we  out  1  CSRs latch the TLB read-port outputs this cycle.
- csr_idx_we  out  1  write back TLBIDX after a search.
- csr_idx_ne  out  1  NE bit to write back.
- csr_idx_index  out  clog2(TLBNUM)  INDEX to write back.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 SHALL run an FSM with states IDLE, DRAIN, EXEC, DONE.
REQ-004 SHALL drive op_ready=1 only in IDLE; an op is accepted when op_valid && op_ready, capturing op_code, inv_op, inv_asid and inv_vpn.
REQ-005 SHALL go IDLE->DRAIN on accept; otherwise stay in IDLE.
REQ-006 SHALL go DRAIN->EXEC in the first DRAIN cycle with trans_idle=1; otherwise stay in DRAIN indefinitely.
REQ-007 SHALL go EXEC->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-008 SHALL assert trans_stall in DRAIN, EXEC and DONE, and deassert it in IDLE.
REQ-009 SHALL, in EXEC for SRCH, assert srch_valid with srch_vppn=csr_tlbehi[31:13], and register srch_found and srch_index.
REQ-010 SHALL, in EXEC for RD, assert rd_we for exactly one cycle.
REQ-011 SHALL, in EXEC for WR, assert tlb_wen with tlb_windex=csr_tlbidx_index.
REQ-012 SHALL, in EXEC for FILL, assert tlb_wen with tlb_windex equal to the fill counter value in that cycle.
REQ-013 SHALL, in EXEC for INV, assert tlbinv_en, with tlbinv_op/asid/vpn driven from the captured fields.
REQ-014 SHALL, for reserved op codes, assert no strobe in EXEC and still pulse done.
REQ-015 SHALL, in DONE, pulse done=1 for every op.
REQ-016 SHALL, in DONE for SRCH only, pulse csr_idx_we with csr_idx_ne=!found_reg and csr_idx_index=found ? index_reg : 0.
REQ-017 SHALL keep a clog2(TLBNUM)-bit fill counter that increments every cycle out of reset and wraps from TLBNUM-1 to 0.
REQ-018 SHALL assert each strobe (srch_valid, tlb_wen, tlbinv_en, rd_we, csr_idx_we, done) for at most one cycle per op.
REQ-019 SHALL have an accept-to-done latency of 3 cycles when trans_idle=1, plus one cycle per extra DRAIN cycle.
REQ-020 SHALL drive all data outputs to 0 when their strobe is low.

Reset
REQ-021 SHALL, while resetn=0, force the state to IDLE, clear the fill counter and captured fields, and drive every output to 0 except op_ready, which is 1 only after reset release.
REQ-022 SHALL, on reset asserted mid-op, abandon the op: no strobe is issued after reset assertion and no done pulse is produced.

Structure
REQ-023 SHALL take the op-code constants, the FSM state enum and the TLBNUM default from the shared core package, also used by the decoder and CSR unit.
REQ-024 SHALL be a single module with no sub-module; the fill counter is inline.

Verification
REQ-025 SHALL cover WR with trans_idle=1 and csr_tlbidx_index=7 -> tlb_wen=1 with tlb_windex=7 exactly 2 cycles after accept, and done 3 cycles after accept.
REQ-026 SHALL cover SRCH with csr_tlbehi=0x00402000, srch_found=1, srch_index=9 -> srch_vppn=0x00201, then csr_idx_we=1, ne=0, index=9; with srch_found=0 -> ne=1, index=0.
REQ-027 SHALL cover INV with trans_idle held 0 for 4 cycles -> trans_stall=1 throughout, and tlbinv_en only in the cycle after trans_idle rises, carrying the captured op/asid/vpn.
REQ-028 SHALL cover FILL accepted 10 cycles after reset release with trans_idle=1 -> tlb_windex=12; a second FILL accepted 28 cycles later wraps correctly mod 32.
REQ-029 SHALL cover op_valid held high during a busy op -> op_ready=0 and no second accept until IDLE; then op_code=6 -> done only, no strobes.
REQ-030 SHALL cover resetn deasserted during DRAIN of a WR -> no tlb_wen, no done, and all outputs 0 on the next edge.
